// File: rtl/fifo_prog.sv
// fifo_prog: single-clock FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow and elaboration-time FWFT selection.
module fifo_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR      = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] CNT_AF   = (ADDR+1)'(AF_THRESH);
    localparam logic [ADDR:0] CNT_AE   = (ADDR+1)'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]    wr_ptr;
    logic [ADDR:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] head;

    // Flags come only from the count register so they never glitch.
    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // Acceptance uses the pre-edge flags: full favours the read, empty the write.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign head = mem[rd_ptr[ADDR-1:0]];

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR-1:0]] <= data_in;
    end

    // Pointers wrap modulo 2*DEPTH; count tracks net accepted operations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)   overflow  <= 1'b1;
            else if (err_clr)    overflow  <= 1'b0;
            if (rd_en && empty)  underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible before the pop; zero when nothing is stored.
            assign data_out = empty ? '0 : head;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            // Registered read: load the head on each accepted pop, hold otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout_q <= '0;
                else if (rd_acc) dout_q <= head;
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: standard-mode instance plus an FWFT instance.
module tb_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // standard-mode instance
    logic       wr_en = 0, rd_en = 0, err_clr = 0;
    logic [7:0] data_in = 0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       f_wr = 0, f_rd = 0, f_clr = 0;
    logic [7:0] f_din = 0;
    logic [7:0] f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_uf;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd), .err_clr(f_clr),
        .data_in(f_din), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ov), .underflow(f_uf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({count, empty, full, almost_empty, almost_full, overflow, underflow, data_out}
            !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL %s: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b uf=%b d=%h expected cnt=0 e=1 f=0 ae=1 af=0 ov=0 uf=0 d=00",
                     tag, count, empty, full, almost_empty, almost_full, overflow, underflow, data_out);
        end
        checks++;
        if ({f_count, f_empty, f_dout, f_ov} !== {5'd0, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL %s_fwft: cnt=%0d e=%b d=%h ov=%b expected 0 1 00 0", tag, f_count, f_empty, f_dout, f_ov);
        end
    endtask

    task automatic test_reset;
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1; data_in = 8'(i);
            tick();
            checks++;
            if (count !== 5'(i) || almost_full !== (i >= 12) || full !== (i == 16)) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d af=%b full=%b expected cnt=%0d af=%b full=%b",
                         i, count, almost_full, full, i, (i >= 12), (i == 16));
            end
        end
        data_in = 8'h11;
        tick();
        wr_en = 0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_17th: cnt=%0d ov=%b expected 16 1", count, overflow);
        end
    endtask

    task automatic test_drain;
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1;
            tick();
            checks++;
            if (data_out !== 8'(k) || count !== 5'(16 - k) || almost_empty !== ((16 - k) <= 4)
                || empty !== (k == 16)) begin
                errors++;
                $display("FAIL drain_%0d: d=%h cnt=%0d ae=%b e=%b expected d=%h cnt=%0d ae=%b e=%b",
                         k, data_out, count, almost_empty, empty, 8'(k), 16 - k, ((16 - k) <= 4), (k == 16));
            end
        end
        tick();
        rd_en = 0;
        checks++;
        if (underflow !== 1'b1 || data_out !== 8'h10 || count !== 5'd0) begin
            errors++;
            $display("FAIL underflow: uf=%b d=%h cnt=%0d expected 1 10 0", underflow, data_out, count);
        end
    endtask

    task automatic test_err_clr;
        err_clr = 1;
        tick();
        err_clr = 0;
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ov=%b uf=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_back_to_back;
        // simultaneous at empty: write taken, read rejected
        wr_en = 1; rd_en = 1; data_in = 8'h50;
        q.push_back(8'h50);
        tick();
        rd_en = 0;
        checks++;
        if (count !== 5'd1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL rw_at_empty: cnt=%0d uf=%b expected 1 1", count, underflow);
        end
        for (int i = 1; i <= 4; i++) begin
            data_in = 8'(8'h50 + i);
            q.push_back(data_in);
            tick();
        end
        // 40 cycles at count=5, crossing the pointer wrap
        rd_en = 1;
        for (int i = 0; i < 40; i++) begin
            data_in = 8'(8'h80 + i);
            q.push_back(data_in);
            exp_d = q.pop_front();
            tick();
            checks++;
            if (count !== 5'd5 || data_out !== exp_d) begin
                errors++;
                $display("FAIL rw_steady_%0d: cnt=%0d d=%h expected cnt=5 d=%h", i, count, data_out, exp_d);
            end
        end
        rd_en = 0;
        for (int i = 0; i < 11; i++) begin
            data_in = 8'(8'hC0 + i);
            q.push_back(data_in);
            tick();
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL refill: full=%b ov=%b expected 1 0", full, overflow);
        end
        // simultaneous at full: read taken, write rejected
        rd_en = 1; data_in = 8'hEE;
        exp_d = q.pop_front();
        tick();
        rd_en = 0;
        checks++;
        if (count !== 5'd15 || overflow !== 1'b1 || data_out !== exp_d) begin
            errors++;
            $display("FAIL rw_at_full: cnt=%0d ov=%b d=%h expected 15 1 %h", count, overflow, data_out, exp_d);
        end
        // re-fill (write lands now), then clear with no event
        data_in = 8'hEF;
        q.push_back(data_in);
        tick();
        wr_en = 0; err_clr = 1;
        tick();
        checks++;
        if (overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL clr_when_full: ov=%b full=%b expected 0 1", overflow, full);
        end
        // clear together with a rejected write: set wins
        wr_en = 1;
        tick();
        wr_en = 0; err_clr = 0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL clr_vs_set: ov=%b cnt=%0d expected 1 16", overflow, count);
        end
    endtask

    task automatic test_fwft;
        f_wr = 1; f_din = 8'hA5;
        tick();
        f_wr = 0;
        checks++;
        if (f_dout !== 8'hA5 || f_empty !== 1'b0 || f_count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_show: d=%h e=%b cnt=%0d expected a5 0 1", f_dout, f_empty, f_count);
        end
        tick();
        checks++;
        if (f_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_hold: d=%h expected a5", f_dout);
        end
        f_rd = 1;
        tick();
        f_rd = 0;
        checks++;
        if (f_dout !== 8'h00 || f_empty !== 1'b1 || f_uf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop: d=%h e=%b uf=%b expected 00 1 0", f_dout, f_empty, f_uf);
        end
        // two words: second appears right after the first pop
        f_wr = 1; f_din = 8'h11;
        tick();
        f_din = 8'h22;
        tick();
        f_wr = 0; f_rd = 1;
        tick();
        f_rd = 0;
        checks++;
        if (f_dout !== 8'h22 || f_count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_next: d=%h cnt=%0d expected 22 1", f_dout, f_count);
        end
    endtask

    task automatic test_reset_mid;
        // drain the standard instance and clear its flags first
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        wr_en = 1; f_wr = 1;
        for (int i = 0; i < 9; i++) begin
            data_in = 8'(8'h30 + i); f_din = data_in;
            tick();
        end
        wr_en = 0; f_wr = 0;
        checks++;
        if (count !== 5'd9 || f_count !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d fcnt=%0d expected 9 9", count, f_count);
        end
        wr_en = 1; rd_en = 1; data_in = 8'h99;
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        wr_en = 0; rd_en = 0;
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1; data_in = 8'h3C;
        tick();
        wr_en = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++;
        if (data_out !== 8'h3C || count !== 5'd0) begin
            errors++;
            $display("FAIL after_reset: d=%h cnt=%0d expected 3c 0", data_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_err_clr();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
